pwm_ramp_ctrl: RTL
==================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000, clock cycles per speed step; legal range 1..65535.
REQ-002 SHALL have parameter DWELL_W, default 16, dwell counter width; DWELL_W bits SHALL hold DWELL_CYCLES-1.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port run_i, input, 1, 1 = drive the motor toward target, 0 = ramp to 0 and stop.
REQ-006 SHALL have port target_i, input, 3, requested speed code 0..7, sampled every cycle.
REQ-007 SHALL have port pwm_en_o, output, 1, enable to the PWM generator.
REQ-008 SHALL have port pwm_speed_o, output, 3, current speed code to the PWM generator.
REQ-009 SHALL have port busy_o, output, 1, high while in RAMP.
REQ-010 SHALL have port at_target_o, output, 1, high while in HOLD.
REQ-011 SHALL have ports fault_i (input, 1, external trip) and fault_o (output, 1, latched trip) only when PWM_FAULT_EN is defined.

Function
REQ-012 SHALL implement FSM states IDLE, RAMP, HOLD; all outputs registered.
REQ-013 Effective target eff SHALL be target_i when run_i=1, else 0.
REQ-014 IDLE: pwm_en_o=0, pwm_speed_o=0; run_i=1 -> RAMP next cycle, dwell counter cleared.
REQ-015 RAMP: pwm_en_o=1; dwell counter counts 0..DWELL_CYCLES-1; at terminal count, cur steps by exactly 1 toward eff and the counter returns to 0.
REQ-016 RAMP: when cur==eff, SHALL go to HOLD if run_i=1, or to IDLE if run_i=0 (cur is then 0); this check takes priority over stepping.
REQ-017 HOLD: pwm_en_o=1, counter held at 0; run_i=0 or target_i!=cur -> RAMP next cycle.
REQ-018 Direction SHALL be re-evaluated at every step; a target change mid-ramp reverses without skipping codes.
REQ-019 cur SHALL saturate at 0 and 7; wrap-around is forbidden.
REQ-020 A full 0->7 ramp SHALL take 7*DWELL_CYCLES cycles in RAMP; DWELL_CYCLES=1 steps every cycle.
REQ-021 IDLE with run_i=1 and target_i=0 SHALL pass RAMP for one cycle, then HOLD with pwm_en_o=1 and speed 0.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, cur=0, counter=0, pwm_en_o=0, pwm_speed_o=0, busy_o=0, at_target_o=0, fault_o=0, including mid-ramp.
REQ-023 After rst_n release, run_i already high SHALL start a ramp on the first clock edge.

Configuration
REQ-024 Macro PWM_FAULT_EN defined: fault_i=1 SHALL force IDLE and pwm_en_o=0, pwm_speed_o=0 next edge, with fault_o=1, overriding all transitions.
REQ-025 With PWM_FAULT_EN, fault_o SHALL clear only when fault_i=0 and run_i=0; IDLE->RAMP SHALL be blocked while fault_o=1.
REQ-026 Without PWM_FAULT_EN: no fault ports, no fault logic.

Structure
REQ-027 Shared package pwm_pkg SHALL hold the state enum (IDLE, RAMP, HOLD), SPEED_W=3, and SPEED_MAX=7.
REQ-028 Dwell counting SHALL be sub-module pwm_dwell_timer (clear, enable, terminal-count output), parameterised by DWELL_CYCLES/DWELL_W.

Verification (DWELL_CYCLES=4 unless stated)
REQ-029 run_i=1, target_i=5 from IDLE -> pwm_en_o=1 one cycle later; speed 1,2,3,4,5 at 4-cycle spacing; at_target_o=1 the cycle after 5 is reached.
REQ-030 At speed 3 ramping to 7, change target_i to 2 -> next step gives 2 (no 4); then HOLD.
REQ-031 In HOLD at 6, run_i=0 -> speed falls to 0 over 24 cycles, then IDLE with pwm_en_o=0, busy_o=0.
REQ-032 rst_n asserted at speed 3 mid-ramp -> all outputs 0 without a clock edge; release with run_i=0 -> stays IDLE.
REQ-033 DWELL_CYCLES=1, target_i=7 -> speed steps every cycle, saturates at 7; a later target_i=7 does not change it.
REQ-034 PWM_FAULT_EN: fault_i pulse in HOLD at 4 -> pwm_en_o=0, speed 0, fault_o=1; run_i stays 1 -> stays IDLE; run_i 0 then 1 -> fault_o clears, ramp restarts.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and speed constants for the PWM ramp controller
package pwm_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_dwell_timer.sv
// rtl/pwm_dwell_timer.sv - dwell counter pacing one speed step per DWELL_CYCLES clocks
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : force the count to 0 (has priority over en_i)
//   en_i       : count 0..DWELL_CYCLES-1, wrapping to 0 after the terminal count
//   tc_o       : count is at DWELL_CYCLES-1
module pwm_dwell_timer #(
    parameter int DWELL_CYCLES = 1000,
    parameter int DWELL_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [DWELL_W-1:0] TC_VAL = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - motor speed ramp FSM (IDLE/RAMP/HOLD) driving a PWM generator
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   fault_i       : external trip (only with PWM_FAULT_EN)
//   fault_o       : latched trip   (only with PWM_FAULT_EN)
//   run_i         : 1 = ramp toward target_i, 0 = ramp down to 0 and stop
//   target_i      : requested speed code 0..7
//   pwm_en_o      : PWM generator enable
//   pwm_speed_o   : current speed code
//   busy_o        : high while ramping
//   at_target_o   : high while holding speed
// Optional feature macro: PWM_FAULT_EN
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int DWELL_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PWM_FAULT_EN
    input  logic               fault_i,
    output logic               fault_o,
`endif
    input  logic               run_i,
    input  logic [SPEED_W-1:0] target_i,
    output logic               pwm_en_o,
    output logic [SPEED_W-1:0] pwm_speed_o,
    output logic               busy_o,
    output logic               at_target_o
);

    pwm_state_e         state_q, state_d;
    logic [SPEED_W-1:0] cur_q, cur_d;
    logic               pwm_en_q, pwm_en_d;
    logic               busy_q, busy_d;
    logic               at_target_q, at_target_d;
    logic [SPEED_W-1:0] eff;
    logic               cnt_en;
    logic               dwell_tc;
    logic               start_ok;

`ifdef PWM_FAULT_EN
    logic fault_q, fault_d;
    assign start_ok = !fault_q;
    assign fault_o  = fault_q;
`else
    assign start_ok = 1'b1;
`endif

    // The dwell counter only runs while there is still distance to cover;
    // otherwise it is held at 0 so every ramp starts with a full dwell.
    assign eff    = run_i ? target_i : '0;
    assign cnt_en = (state_q == RAMP) && (cur_q != eff);

    pwm_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .DWELL_W      (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!cnt_en),
        .en_i  (cnt_en),
        .tc_o  (dwell_tc)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: begin
                if (run_i && start_ok) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                // Arrival check wins over stepping; direction is re-derived
                // at every step so a target change reverses without skipping.
                if (cur_q == eff) begin
                    state_d = run_i ? HOLD : IDLE;
                end else if (dwell_tc) begin
                    if (cur_q < eff && cur_q != SPEED_MAX) begin
                        cur_d = cur_q + 1'b1;
                    end else if (cur_q > eff && cur_q != '0) begin
                        cur_d = cur_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!run_i || target_i != cur_q) begin
                    state_d = RAMP;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PWM_FAULT_EN
        // A trip overrides every transition; the latch is released only
        // once the operator has dropped run_i with the trip gone.
        fault_d = fault_q;
        if (fault_i) begin
            state_d = IDLE;
            cur_d   = '0;
            fault_d = 1'b1;
        end else if (!run_i) begin
            fault_d = 1'b0;
        end
`endif

        pwm_en_d    = (state_d != IDLE);
        busy_d      = (state_d == RAMP);
        at_target_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            pwm_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
`ifdef PWM_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pwm_en_q    <= pwm_en_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
`ifdef PWM_FAULT_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign pwm_en_o    = pwm_en_q;
    assign pwm_speed_o = cur_q;
    assign busy_o      = busy_q;
    assign at_target_o = at_target_q;

endmodule
